// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD types, constants and helpers for the BCD counters and timers
package bcd_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} bcd_tmr_state_t;
    localparam logic [3:0] BCD_MAX = 4'd9;
    function automatic logic is_bcd(input logic [3:0] nibble);
        return nibble <= BCD_MAX;
    endfunction
endpackage

// File: rtl/bcd_down_timer_if.sv
// bcd_down_timer_if: control/status bundle between a timer and its controller
interface bcd_down_timer_if #(parameter int DIGITS = 4);
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic                  start;
    logic                  pause;
    logic                  tick;
    logic [4*DIGITS-1:0]   count;
    logic                  busy;
    logic                  done;
    logic                  load_err;
    modport master (output load, load_val, start, pause, tick, input count, busy, done, load_err);
    modport slave  (input load, load_val, start, pause, tick, output count, busy, done, load_err);
endinterface

// File: rtl/bcd_down_digit.sv
// bcd_down_digit: one BCD digit decrement cell; 0 wraps to 9 and borrows onward
import bcd_pkg::*;
module bcd_down_digit (
    input  logic [3:0] digit_i,
    input  logic       borrow_i,
    output logic [3:0] digit_o,
    output logic       borrow_o
);
    assign borrow_o = borrow_i && digit_i == 4'd0;
    assign digit_o  = !borrow_i ? digit_i : (digit_i == 4'd0 ? BCD_MAX : digit_i - 4'd1);
endmodule

// File: rtl/bcd_down_timer.sv
// bcd_down_timer: loadable multi-digit BCD countdown with pause/resume, done pulse
// and optional auto-reload at terminal count
import bcd_pkg::*;
module bcd_down_timer #(
    parameter int DIGITS      = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input logic              clk,
    input logic              reset,
    bcd_down_timer_if.slave  tmr
);
    localparam int W = 4 * DIGITS;
    bcd_tmr_state_t state_q, state_d;
    logic [W-1:0]   count_q, count_d, reload_q, reload_d, dec;
    logic           done_q, done_d, err_q, err_d;
    logic [DIGITS:0]   borrow;
    logic [DIGITS-1:0] nib_ok;
    logic           nonzero;
    assign borrow[0] = 1'b1;
    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        bcd_down_digit u_dig (
            .digit_i  (count_q[4*i +: 4]),
            .borrow_i (borrow[i]),
            .digit_o  (dec[4*i +: 4]),
            .borrow_o (borrow[i+1])
        );
        assign nib_ok[i] = is_bcd(tmr.load_val[4*i +: 4]);
    end
    // a borrow out of the top digit means every digit was zero
    assign nonzero = !borrow[DIGITS];
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        err_d    = err_q;
        if (tmr.load) begin
            err_d = !(&nib_ok);
            if (&nib_ok) begin
                count_d  = tmr.load_val;
                reload_d = tmr.load_val;
                state_d  = IDLE;
            end
        end else if (tmr.pause) begin
            state_d = state_q == RUN ? PAUSE : state_q;
        end else if (tmr.start) begin
            state_d = (state_q == PAUSE || (state_q == IDLE && nonzero)) ? RUN : state_q;
        end else if (tmr.tick && state_q == RUN && nonzero) begin
            if (count_q == W'(1)) begin
                done_d  = 1'b1;
                count_d = AUTO_RELOAD ? reload_q : '0;
                state_d = AUTO_RELOAD ? RUN : IDLE;
            end else begin
                count_d = dec;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end
    assign tmr.count    = count_q;
    assign tmr.busy     = state_q != IDLE;
    assign tmr.done     = done_q;
    assign tmr.load_err = err_q;
endmodule

// File: tb/tb_bcd_down_timer.sv
// tb_bcd_down_timer: directed checks of the BCD countdown timer, plain and auto-reload
module tb_bcd_down_timer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int total = 0;
    int bad = 0;
    bcd_down_timer_if #(.DIGITS(4)) if0 ();
    bcd_down_timer_if #(.DIGITS(4)) if1 ();
    bcd_down_timer #(.DIGITS(4), .AUTO_RELOAD(1'b0)) u0 (.clk(clk), .reset(reset), .tmr(if0));
    bcd_down_timer #(.DIGITS(4), .AUTO_RELOAD(1'b1)) u1 (.clk(clk), .reset(reset), .tmr(if1));
    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int n);
        return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic load0(input logic [15:0] v);
        if0.load = 1'b1;
        if0.load_val = v;
        cyc();
        if0.load = 1'b0;
    endtask

    task automatic start0();
        if0.start = 1'b1;
        cyc();
        if0.start = 1'b0;
    endtask

    task automatic ticks0(input int n);
        if0.tick = 1'b1;
        repeat (n) cyc();
        if0.tick = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (if0.count !== 16'h0 || if0.busy !== 1'b0 || if0.done !== 1'b0 || if0.load_err !== 1'b0) begin
            bad++;
            $display("FAIL reset0: count=%h busy=%b done=%b err=%b want 0000 0 0 0", if0.count, if0.busy, if0.done, if0.load_err);
        end
        total++;
        if (if1.count !== 16'h0 || if1.busy !== 1'b0 || if1.done !== 1'b0) begin
            bad++;
            $display("FAIL reset1: count=%h busy=%b done=%b want 0000 0 0", if1.count, if1.busy, if1.done);
        end
    endtask

    task automatic test_basic();
        load0(16'h0012);
        start0();
        total++;
        if (if0.busy !== 1'b1 || if0.count !== 16'h0012) begin
            bad++;
            $display("FAIL basic_start: busy=%b count=%h want 1 0012", if0.busy, if0.count);
        end
        if0.tick = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            total++;
            if (if0.count !== to_bcd(12 - i) || if0.done !== (i == 12)) begin
                bad++;
                $display("FAIL basic_tick%0d: count=%h done=%b want %h %b", i, if0.count, if0.done, to_bcd(12 - i), i == 12);
            end
        end
        cyc();
        if0.tick = 1'b0;
        total++;
        if (if0.count !== 16'h0 || if0.busy !== 1'b0 || if0.done !== 1'b0) begin
            bad++;
            $display("FAIL basic_after: count=%h busy=%b done=%b want 0000 0 0", if0.count, if0.busy, if0.done);
        end
    endtask

    task automatic test_borrow();
        load0(16'h1000);
        start0();
        ticks0(1);
        total++;
        if (if0.count !== 16'h0999) begin
            bad++;
            $display("FAIL borrow_first: count=%h want 0999", if0.count);
        end
        if0.tick = 1'b1;
        for (int k = 1; k <= 999; k++) begin
            cyc();
            total++;
            if (if0.count !== to_bcd(999 - k) || if0.done !== (k == 999)) begin
                bad++;
                $display("FAIL borrow_tick%0d: count=%h done=%b want %h %b", k, if0.count, if0.done, to_bcd(999 - k), k == 999);
            end
        end
        repeat (3) cyc();
        if0.tick = 1'b0;
        total++;
        if (if0.count !== 16'h0 || if0.done !== 1'b0 || if0.busy !== 1'b0) begin
            bad++;
            $display("FAIL borrow_floor: count=%h done=%b busy=%b want 0000 0 0", if0.count, if0.done, if0.busy);
        end
    endtask

    task automatic test_load_err();
        do_reset();
        load0(16'h00A5);
        total++;
        if (if0.load_err !== 1'b1 || if0.count !== 16'h0) begin
            bad++;
            $display("FAIL err_bad: err=%b count=%h want 1 0000", if0.load_err, if0.count);
        end
        load0(16'h0005);
        total++;
        if (if0.load_err !== 1'b0 || if0.count !== 16'h0005) begin
            bad++;
            $display("FAIL err_good: err=%b count=%h want 0 0005", if0.load_err, if0.count);
        end
    endtask

    task automatic test_pause();
        load0(16'h0009);
        if0.start = 1'b1;
        if0.tick = 1'b1;
        cyc();
        if0.start = 1'b0;
        if0.tick = 1'b0;
        total++;
        if (if0.count !== 16'h0009 || if0.busy !== 1'b1) begin
            bad++;
            $display("FAIL pause_start_tick: count=%h busy=%b want 0009 1", if0.count, if0.busy);
        end
        ticks0(3);
        total++;
        if (if0.count !== 16'h0006) begin
            bad++;
            $display("FAIL pause_run3: count=%h want 0006", if0.count);
        end
        if0.pause = 1'b1;
        cyc();
        if0.pause = 1'b0;
        ticks0(5);
        total++;
        if (if0.count !== 16'h0006 || if0.busy !== 1'b1) begin
            bad++;
            $display("FAIL pause_hold: count=%h busy=%b want 0006 1", if0.count, if0.busy);
        end
        start0();
        ticks0(2);
        total++;
        if (if0.count !== 16'h0004) begin
            bad++;
            $display("FAIL pause_resume: count=%h want 0004", if0.count);
        end
        if0.start = 1'b1;
        if0.pause = 1'b1;
        cyc();
        if0.start = 1'b0;
        if0.pause = 1'b0;
        ticks0(2);
        total++;
        if (if0.count !== 16'h0004 || if0.busy !== 1'b1) begin
            bad++;
            $display("FAIL pause_wins: count=%h busy=%b want 0004 1", if0.count, if0.busy);
        end
        start0();
        ticks0(1);
        total++;
        if (if0.count !== 16'h0003) begin
            bad++;
            $display("FAIL pause_resume2: count=%h want 0003", if0.count);
        end
    endtask

    task automatic test_reload();
        logic [15:0] exp_c [6];
        exp_c = '{16'h2, 16'h1, 16'h3, 16'h2, 16'h1, 16'h3};
        if1.load = 1'b1;
        if1.load_val = 16'h0003;
        cyc();
        if1.load = 1'b0;
        if1.start = 1'b1;
        cyc();
        if1.start = 1'b0;
        if1.tick = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            total++;
            if (if1.count !== exp_c[i] || if1.done !== (i == 2 || i == 5) || if1.busy !== 1'b1) begin
                bad++;
                $display("FAIL reload_tick%0d: count=%h done=%b busy=%b want %h %b 1", i + 1, if1.count, if1.done, if1.busy, exp_c[i], i == 2 || i == 5);
            end
        end
        if1.tick = 1'b0;
    endtask

    task automatic test_start_zero_and_reset();
        do_reset();
        start0();
        total++;
        if (if0.busy !== 1'b0 || if0.done !== 1'b0) begin
            bad++;
            $display("FAIL zero_start: busy=%b done=%b want 0 0", if0.busy, if0.done);
        end
        load0(16'h0050);
        start0();
        ticks0(10);
        total++;
        if (if0.count !== 16'h0040 || if0.busy !== 1'b1) begin
            bad++;
            $display("FAIL midrun: count=%h busy=%b want 0040 1", if0.count, if0.busy);
        end
        load0(16'h00F0);
        do_reset();
        total++;
        if (if0.count !== 16'h0 || if0.busy !== 1'b0 || if0.done !== 1'b0 || if0.load_err !== 1'b0) begin
            bad++;
            $display("FAIL midrun_reset: count=%h busy=%b done=%b err=%b want 0000 0 0 0", if0.count, if0.busy, if0.done, if0.load_err);
        end
    endtask

    initial begin
        {if0.load, if0.start, if0.pause, if0.tick} = '0;
        {if1.load, if1.start, if1.pause, if1.tick} = '0;
        if0.load_val = '0;
        if1.load_val = '0;
        test_reset();
        test_basic();
        test_borrow();
        test_load_err();
        test_pause();
        test_reload();
        test_start_zero_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bcd_down_timer.md
# bcd_down_timer

Multi-digit BCD countdown timer; the decrementing counterpart to the team's decade up-counter. It loads a BCD value, counts down one step per `tick` strobe while running, and flags terminal count with a one-cycle `done` pulse. Pause/resume and optional auto-reload are supported. It sits next to the BCD up-counters in the timing/display datapath and drives the same BCD display decoders.

## Interface
- `DIGITS`, default 4: number of BCD digits; count width is 4*DIGITS.
- `AUTO_RELOAD`, default 0: 1 = reload the last loaded value at terminal count and keep running.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `load` in 1: capture `load_val` into count and reload registers.
- `load_val` in 4*DIGITS: BCD value, digit 0 in bits [3:0].
- `start` in 1: begin or resume counting.
- `pause` in 1: suspend counting.
- `tick` in 1: decrement strobe, one count per cycle high.
- `count` out 4*DIGITS: current BCD count, registered.
- `busy` out 1: high in RUN and PAUSE.
- `done` out 1: one-cycle pulse at terminal count.
- `load_err` out 1: sticky; last `load_val` held a nibble > 9.

## Operation
- FSM states: IDLE, RUN, PAUSE.
- Per-cycle priority: reset > load > pause > start > tick.
- Reset values: count=0, reload=0, busy=0, done=0, load_err=0, state=IDLE.
- `load` with all nibbles ≤ 9:
  - count and reload take `load_val`.
  - load_err clears.
  - State goes to IDLE from any state.
- `load` with any nibble > 9: load_err=1; count, reload and state are unchanged.
- `start`:
  - In IDLE with count≠0: go to RUN.
  - In IDLE with count=0: ignored; stay IDLE, no `done`.
  - In PAUSE: go to RUN.
  - In RUN: no effect.
- `pause`:
  - In RUN: go to PAUSE.
  - Ignored elsewhere.
  - Wins over `start` when both are high in the same cycle.
- `tick` is honoured only in RUN and is ignored in IDLE and PAUSE.
- Decrement with borrow:
  - Digit 0 decrements.
  - A digit at 0 wraps to 9 and borrows from the next digit.
  - Example: 0x1000 → 0x0999.
- Terminal count is a tick in RUN while count=1 (value one).
  - AUTO_RELOAD=0: count←0, done=1, go to IDLE.
  - AUTO_RELOAD=1: count←reload, done=1, stay RUN.
- Count never decrements below 0; there is no wrap from 0 to 99..9.
- `done` is high for exactly one cycle per terminal count; it is cleared on every other cycle.

## Timing
- All outputs are registered. Every change is visible the cycle after the causing input is sampled on a `clk` edge.
- Decrement latency is 1 cycle: `tick` sampled high at edge N gives the new count after edge N.
- `done` asserts on the same edge where count becomes 0 (or reloads), for one cycle.
- `busy` deasserts on that same edge when AUTO_RELOAD=0.
- `start` followed by `tick` in the next cycle: that tick is counted. A `tick` in the same cycle as `start` from IDLE/PAUSE is not counted.
- Reset mid-count returns all outputs to reset values at the next edge. No `done` is emitted.
- Back-to-back ticks decrement every cycle.
- Borrow ripples combinationally across all digits within one cycle.

## Structure
- Shared package `bcd_pkg` holds:
  - State enum `bcd_tmr_state_t` (IDLE, RUN, PAUSE).
  - Constant `BCD_MAX = 4'd9`.
  - Function `is_bcd(nibble)`, also reused by the up-counter benches.
- Sub-module `bcd_down_digit`:
  - Combinational cell with inputs digit and borrow_in, outputs next digit and borrow_out.
  - Instantiated DIGITS times in a generate loop.
- The top holds the FSM, count/reload registers, validity check and output registers.

## Test plan
All scenarios use DIGITS=4.
1. Reset, load 0x0012, start, 12 ticks → count steps down 0x0011 … 0x0000; done pulses only on the 12th tick; busy=0 afterwards; state IDLE.
2. Load 0x1000, start, 1 tick → count=0x0999. Then 999 more ticks → done pulse with count=0x0000. No further decrement on extra ticks.
3. Load 0x00A5 → load_err=1 and count unchanged (0). Then load 0x0005 → load_err=0, count=0x0005.
4. Load 0x0009, start, 3 ticks (0x0006), pause, 5 ticks → count stays 0x0006, busy=1. Start, 2 ticks → 0x0004. Start+pause in the same cycle → PAUSE.
5. AUTO_RELOAD=1, load 0x0003, start, 6 ticks → done pulses on ticks 3 and 6, count=0x0003 after each, busy stays 1.
6. Start with count=0 → stays IDLE, no done. Load 0x0050, start, 10 ticks, then reset → count=0, busy=0, done=0, load_err=0 at the next edge.
